// File: rtl/imm_encoder_pkg.sv
// Shared processor package: immediate-type control codes, IW-type instruction
// layout and the constant-materialisation FSM states.
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    IMM_CTRL_NONE = 3'd0,
    IMM_CTRL_I    = 3'd1,
    IMM_CTRL_S    = 3'd2,
    IMM_CTRL_B    = 3'd3,
    IMM_CTRL_IW   = 3'd4
  } imm_ctrl_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } enc_state_e;

  localparam logic [8:0] OP_MOVZ = 9'b110100101;
  localparam logic [8:0] OP_MOVK = 9'b111100101;

  // IW-type word: [31:23] opcode, [22:21] hw, [20:5] imm16, [4:0] rd
  localparam int IW_OP_LSB  = 23;
  localparam int IW_OP_W    = 9;
  localparam int IW_HW_LSB  = 21;
  localparam int IW_HW_W    = 2;
  localparam int IW_IMM_LSB = 5;
  localparam int IW_IMM_W   = 16;
  localparam int IW_RD_LSB  = 0;
  localparam int IW_RD_W    = 5;

  function automatic logic [1:0] lowest_hw(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else if (m[3]) return 2'd3;
    else           return 2'd0;
  endfunction

endpackage

// File: rtl/imm_encoder_iw_formatter.sv
// Combinational packer for one IW-type MOVZ/MOVK instruction word.
module iw_formatter
  import imm_encoder_pkg::*;
(
  input  logic        movk,
  input  logic [1:0]  hw,
  input  logic [15:0] imm,
  input  logic [4:0]  rd,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    word[IW_OP_LSB  +: IW_OP_W]  = movk ? OP_MOVK : OP_MOVZ;
    word[IW_HW_LSB  +: IW_HW_W]  = hw;
    word[IW_IMM_LSB +: IW_IMM_W] = imm;
    word[IW_RD_LSB  +: IW_RD_W]  = rd;
  end

endmodule

// File: rtl/imm_encoder.sv
// Expands a 64-bit constant into a MOVZ + up to three MOVK words, one word per
// accepted output handshake, lowest halfword first.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int SKIP_ZERO = 1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [63:0] InConst,
  input  logic [4:0]  InRd,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstr,
  output logic        OutLast,
  output logic        Busy
);

  enc_state_e  state, state_nxt;
  logic [3:0]  mask_p0;
  logic [63:0] cnst_p0;
  logic [4:0]  rd_p0;
  logic        movk_p0;

  logic [3:0]  mask_init;
  logic [1:0]  hw_cur;
  logic [15:0] imm_cur;
  logic        last_cur;
  logic        accept, take;
  logic [31:0] word;

  // A zero constant still needs one MOVZ hw0 to clear the register.
  always_comb begin
    mask_init = '0;
    for (int i = 0; i < 4; i++)
      mask_init[i] = (SKIP_ZERO == 0) || (InConst[16*i +: 16] != 16'h0);
    if (mask_init == 4'b0000)
      mask_init = 4'b0001;
  end

  assign hw_cur   = lowest_hw(mask_p0);
  assign imm_cur  = cnst_p0[{hw_cur, 4'b0000} +: 16];
  assign last_cur = (mask_p0 & ~(4'b0001 << hw_cur)) == 4'b0000;

  assign Busy     = (state == ST_EMIT);
  assign InReady  = (state == ST_IDLE);
  assign OutValid = Busy;
  assign OutLast  = Busy && last_cur;
  assign OutInstr = Busy ? word : 32'h0;

  assign accept = InValid && InReady;
  assign take   = OutValid && OutReady;

  iw_formatter u_fmt (
    .movk (movk_p0),
    .hw   (hw_cur),
    .imm  (imm_cur),
    .rd   (rd_p0),
    .word (word)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)           state_nxt = ST_EMIT;
      ST_EMIT: if (take && last_cur) state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: captured request and pending-halfword mask
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mask_p0 <= '0;
      cnst_p0 <= '0;
      rd_p0   <= '0;
      movk_p0 <= 1'b0;
    end else if (accept) begin
      mask_p0 <= mask_init;
      cnst_p0 <= InConst;
      rd_p0   <= InRd;
      movk_p0 <= 1'b0;
    end else if (take) begin
      mask_p0 <= mask_p0 & ~(4'b0001 << hw_cur);
      movk_p0 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Randomised bench for imm_encoder against a halfword-list reference model and
// a MOVZ/MOVK executor.
`timescale 1ns/1ps
module tb_imm_encoder;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        InValid, InReady, OutValid, OutReady, OutLast, Busy;
  logic [63:0] InConst;
  logic [4:0]  InRd;
  logic [31:0] OutInstr;

  logic        z_InValid, z_InReady, z_OutValid, z_OutReady, z_OutLast, z_Busy;
  logic [63:0] z_InConst;
  logic [4:0]  z_InRd;
  logic [31:0] z_OutInstr;

  always #5 CLK = ~CLK;

  imm_encoder #(.SKIP_ZERO(1)) dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InConst(InConst), .InRd(InRd), .OutValid(OutValid), .OutReady(OutReady),
    .OutInstr(OutInstr), .OutLast(OutLast), .Busy(Busy)
  );

  imm_encoder #(.SKIP_ZERO(0)) dut_z (
    .CLK(CLK), .Reset(Reset), .InValid(z_InValid), .InReady(z_InReady),
    .InConst(z_InConst), .InRd(z_InRd), .OutValid(z_OutValid), .OutReady(z_OutReady),
    .OutInstr(z_OutInstr), .OutLast(z_OutLast), .Busy(z_Busy)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] got_w[$];
  logic        got_l[$];
  logic [31:0] exp_w[$];
  int          stall_viol, first_lat, wait_cyc;
  bit          timed_out;

  function automatic logic [31:0] enc(input bit movk, input int hw,
                                      input logic [15:0] imm, input logic [4:0] rd);
    longint v;
    v = (movk ? 64'hF280_0000 : 64'hD280_0000) + longint'(hw) * 2097152
        + longint'(imm) * 32 + longint'(rd);
    return v[31:0];
  endfunction

  task automatic build_exp(input logic [63:0] c, input logic [4:0] rd, input bit skip);
    exp_w.delete();
    for (int h = 0; h < 4; h++) begin
      logic [15:0] imm;
      imm = c[16*h +: 16];
      if (!skip || imm != 16'h0)
        exp_w.push_back(enc(exp_w.size() != 0, h, imm, rd));
    end
    if (exp_w.size() == 0) exp_w.push_back(enc(1'b0, 0, 16'h0, rd));
  endtask

  // Executes the captured words as a processor would and returns Rd.
  function automatic logic [63:0] exec_words();
    logic [63:0] r;
    r = '0;
    foreach (got_w[i]) begin
      logic [8:0]  op;
      logic [63:0] imm;
      int          sh;
      op  = got_w[i][31:23];
      imm = {48'h0, got_w[i][20:5]};
      sh  = 16 * int'(got_w[i][22:21]);
      if (op == 9'b110100101) r = imm << sh;
      else                    r = (r & ~(64'hFFFF << sh)) | (imm << sh);
    end
    return r;
  endfunction

  // mode 0: always ready, 1: ready toggles 1/0, 2: random ready
  task automatic collect(input logic [63:0] c, input logic [4:0] rd,
                         input int mode, input bit hold_valid);
    int          cyc;
    bit          done, pstall;
    logic [31:0] pw;
    logic        pl;
    got_w.delete(); got_l.delete();
    stall_viol = 0; first_lat = -1; wait_cyc = 0; timed_out = 0;
    done = 0; pstall = 0; pw = '0; pl = 1'b0;
    InConst = c; InRd = rd; InValid = 1'b1; OutReady = 1'b0;
    while (!InReady && wait_cyc < 50) begin
      @(posedge CLK); #1; wait_cyc++;
    end
    if (!InReady) begin
      timed_out = 1; InValid = 1'b0; return;
    end
    @(posedge CLK); #1;
    if (!hold_valid) InValid = 1'b0;
    InConst = {$urandom, $urandom};
    InRd    = 5'($urandom);
    cyc = 1;
    while (!done && cyc < 200) begin
      case (mode)
        0:       OutReady = 1'b1;
        1:       OutReady = cyc[0];
        default: OutReady = 1'($urandom_range(0, 1));
      endcase
      if (OutValid && first_lat < 0) first_lat = cyc;
      if (pstall && (OutInstr !== pw || OutLast !== pl)) stall_viol++;
      if (OutValid && OutReady) begin
        got_w.push_back(OutInstr);
        got_l.push_back(OutLast);
        if (OutLast) done = 1;
      end
      pstall = OutValid && !OutReady;
      pw = OutInstr; pl = OutLast;
      @(posedge CLK); #1;
      cyc++;
    end
    OutReady = 1'b0;
    if (!done) timed_out = 1;
  endtask

  task automatic check_seq(input string name, input logic [63:0] c);
    n_cmp++;
    if (timed_out) begin
      n_bad++; $display("FAIL %s timeout: sequence did not finish", name); return;
    end
    n_cmp++;
    if (got_w.size() != exp_w.size()) begin
      n_bad++;
      $display("FAIL %s count: got %0d words, want %0d", name, got_w.size(), exp_w.size());
      return;
    end
    foreach (exp_w[i]) begin
      n_cmp++;
      if (got_w[i] !== exp_w[i]) begin
        n_bad++; $display("FAIL %s word%0d: got %h want %h", name, i, got_w[i], exp_w[i]);
      end
      n_cmp++;
      if (got_l[i] !== (i == exp_w.size() - 1)) begin
        n_bad++; $display("FAIL %s last%0d: got %b want %b", name, i, got_l[i], i == exp_w.size() - 1);
      end
    end
    n_cmp++;
    if (exec_words() !== c) begin
      n_bad++; $display("FAIL %s roundtrip: got %h want %h", name, exec_words(), c);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    InValid = 0; OutReady = 0; InConst = '0; InRd = '0;
    z_InValid = 0; z_OutReady = 0; z_InConst = '0; z_InRd = '0;
    #2 Reset = 1'b1;
    #2;
    n_cmp++; if (InReady !== 1'b1)   begin n_bad++; $display("FAIL reset_inready: got %b want 1", InReady); end
    n_cmp++; if (OutValid !== 1'b0)  begin n_bad++; $display("FAIL reset_outvalid: got %b want 0", OutValid); end
    n_cmp++; if (OutLast !== 1'b0)   begin n_bad++; $display("FAIL reset_outlast: got %b want 0", OutLast); end
    n_cmp++; if (Busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_cmp++; if (OutInstr !== 32'h0) begin n_bad++; $display("FAIL reset_outinstr: got %h want 0", OutInstr); end
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_directed();
    collect(64'h0000_0000_0000_1234, 5'd3, 0, 0);
    build_exp(64'h0000_0000_0000_1234, 5'd3, 1);
    n_cmp++; if (exp_w[0] !== 32'hD282_4683) begin n_bad++; $display("FAIL model_1234: got %h want D2824683", exp_w[0]); end
    check_seq("single_1234", 64'h0000_0000_0000_1234);
    n_cmp++; if (first_lat != 1) begin n_bad++; $display("FAIL latency: got %0d want 1", first_lat); end

    collect(64'h1234_0000_0000_ABCD, 5'd0, 0, 0);
    exp_w.delete(); exp_w.push_back(32'hD295_79A0); exp_w.push_back(32'hF2E2_4680);
    check_seq("two_word", 64'h1234_0000_0000_ABCD);

    collect(64'h0, 5'd0, 0, 0);
    exp_w.delete(); exp_w.push_back(32'hD280_0000);
    check_seq("zero_const", 64'h0);
  endtask

  task automatic test_stall();
    collect(64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1, 0);
    build_exp(64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1);
    check_seq("stall_ones", 64'hFFFF_FFFF_FFFF_FFFF);
    n_cmp++; if (stall_viol != 0) begin n_bad++; $display("FAIL stall_hold: got %0d changes want 0", stall_viol); end
  endtask

  task automatic test_reset_mid();
    int leak;
    leak = 0;
    InConst = 64'hFFFF_FFFF_FFFF_FFFF; InRd = 5'd1; InValid = 1'b1; OutReady = 1'b0;
    n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle: got %b want 1", InReady); end
    @(posedge CLK); #1;
    InValid = 1'b0; OutReady = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    Reset = 1'b1;
    #1;
    n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL rstmid_outvalid: got %b want 0", OutValid); end
    n_cmp++; if (InReady !== 1'b1)  begin n_bad++; $display("FAIL rstmid_inready: got %b want 1", InReady); end
    @(posedge CLK); #1;
    Reset = 1'b0;
    repeat (6) begin
      @(posedge CLK); #1;
      if (OutValid !== 1'b0 || Busy !== 1'b0) leak++;
    end
    n_cmp++; if (leak != 0) begin n_bad++; $display("FAIL rstmid_resume: got %0d active cycles want 0", leak); end
    OutReady = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      logic [63:0] c;
      logic [3:0]  zpat;
      logic [4:0]  rd;
      c = {$urandom, $urandom};
      zpat = 4'($urandom_range(0, 15));
      for (int h = 0; h < 4; h++) if (zpat[h]) c[16*h +: 16] = 16'h0;
      rd = 5'($urandom);
      collect(c, rd, 2, 0);
      build_exp(c, rd, 1);
      check_seq($sformatf("random%0d", k), c);
      n_cmp++; if (stall_viol != 0) begin n_bad++; $display("FAIL random%0d_hold: got %0d changes want 0", k, stall_viol); end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      logic [63:0] c;
      logic [4:0]  rd;
      c = {$urandom, $urandom};
      if (k == 2) c[31:16] = 16'h0;
      rd = 5'(k + 20);
      collect(c, rd, 0, 1);
      build_exp(c, rd, 1);
      check_seq($sformatf("b2b%0d", k), c);
      if (k > 0) begin
        n_cmp++; if (wait_cyc != 0) begin n_bad++; $display("FAIL b2b%0d_accept: got %0d wait cycles want 0", k, wait_cyc); end
      end
    end
    InValid = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_noskip();
    logic [63:0] cs[2];
    cs[0] = 64'h0000_BEEF_0000_0000;
    cs[1] = 64'h0;
    for (int k = 0; k < 2; k++) begin
      int cyc;
      bit done;
      got_w.delete(); got_l.delete();
      z_InConst = cs[k]; z_InRd = 5'd7; z_InValid = 1'b1; z_OutReady = 1'b1;
      @(posedge CLK); #1;
      z_InValid = 1'b0;
      cyc = 0; done = 0;
      while (!done && cyc < 20) begin
        if (z_OutValid && z_OutReady) begin
          got_w.push_back(z_OutInstr); got_l.push_back(z_OutLast);
          if (z_OutLast) done = 1;
        end
        @(posedge CLK); #1; cyc++;
      end
      timed_out = !done;
      build_exp(cs[k], 5'd7, 0);
      check_seq($sformatf("noskip%0d", k), cs[k]);
      z_OutReady = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_noskip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter SKIP_ZERO, default 1, meaning: 1 omits all-zero halfwords, 0 emits all four halfwords.
REQ-002 SHALL have port CLK, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port InValid, input, 1, meaning a constant request is presented.
REQ-005 SHALL have port InReady, output, 1, meaning the block accepts a request this cycle.
REQ-006 SHALL have port InConst, input, 64, the constant to materialize.
REQ-007 SHALL have port InRd, input, 5, the destination register number.
REQ-008 SHALL have port OutValid, output, 1, meaning OutInstr holds a valid instruction word.
REQ-009 SHALL have port OutReady, input, 1, meaning the consumer takes OutInstr this cycle.
REQ-010 SHALL have port OutInstr, output, 32, the encoded IW-type instruction.
REQ-011 SHALL have port OutLast, output, 1, meaning OutInstr is the final word of the current sequence.
REQ-012 SHALL have port Busy, output, 1, high whenever a sequence is in progress.

Function
REQ-013 SHALL convert one 64-bit constant into a MOVZ followed by zero to three MOVK words; executed in order, they leave Rd equal to InConst.
REQ-014 SHALL encode each word as: [31:23] opcode, [22:21] hw, [20:5] imm16, [4:0] Rd.
REQ-015 SHALL use opcode 9'b110100101 for MOVZ and 9'b111100101 for MOVK.
REQ-016 SHALL set imm16 = InConst[16*hw+15 : 16*hw].
REQ-017 SHALL emit halfwords in ascending hw order (0..3).
REQ-018 SHALL make the first emitted word MOVZ and every later word MOVK.
REQ-019 SHALL, with SKIP_ZERO=1, emit only halfwords that are nonzero.
REQ-020 SHALL, with SKIP_ZERO=1 and InConst==0, emit exactly one word: MOVZ hw=0 imm16=0.
REQ-021 SHALL, with SKIP_ZERO=0, emit exactly four words, hw=0..3.
REQ-022 SHALL implement an FSM with states IDLE and EMIT.
REQ-023 SHALL drive InReady=1 only in IDLE.
REQ-024 SHALL accept a request on InValid&&InReady: capture InConst and InRd, build the 4-bit pending-halfword mask, go to EMIT.
REQ-025 SHALL present the first word in the cycle after acceptance (latency 1).
REQ-026 SHALL drive OutValid=1 throughout EMIT and 0 in IDLE.
REQ-027 SHALL hold OutInstr and OutLast stable while OutValid&&!OutReady.
REQ-028 SHALL, on OutValid&&OutReady, clear the current halfword's mask bit and advance to the lowest remaining set bit.
REQ-029 SHALL assert OutLast when no mask bit other than the current one remains.
REQ-030 SHALL return to IDLE on a handshake while OutLast=1.
REQ-031 SHALL NOT accept a new request in the cycle a last word is taken; the earliest acceptance is the following IDLE cycle.
REQ-032 SHALL set Busy = (state==EMIT).
REQ-033 SHALL ignore InConst and InRd changes after acceptance.
REQ-034 SHALL ignore InValid while in EMIT.
REQ-035 SHALL sustain 1 word per cycle while OutReady=1.

Reset
REQ-036 SHALL, on Reset, immediately (asynchronously) enter IDLE and clear the mask, captured constant and captured Rd.
REQ-037 SHALL hold these reset output values: InReady=1, OutValid=0, OutLast=0, Busy=0, OutInstr=32'h0.
REQ-038 SHALL, when Reset asserts mid-sequence, abandon the sequence without emitting further words and without resuming after Reset deasserts.

Structure
REQ-039 SHALL place the opcode constants (MOVZ, MOVK), IW field bit positions and the FSM state encodings in the shared processor package alongside the existing immediate-type Ctrl codes.
REQ-040 SHALL keep word formatting (opcode, hw, imm16, Rd -> 32 bits) in a combinational sub-module named iw_formatter; the FSM, mask and handshake stay in imm_encoder.

Verification
REQ-041 SHALL cover: InConst=64'h0000_0000_0000_1234, Rd=3 -> one word 32'hD282_4683, OutLast=1.
REQ-042 SHALL cover: InConst=64'h1234_0000_0000_ABCD, Rd=0 -> MOVZ hw0 imm ABCD (32'hD295_79A0), then MOVK hw3 imm 1234 (32'hF2E2_4680, OutLast=1).
REQ-043 SHALL cover: InConst=0, SKIP_ZERO=1 -> single word 32'hD280_0000 (Rd=0), OutLast=1.
REQ-044 SHALL cover: InConst=64'hFFFF_FFFF_FFFF_FFFF, OutReady toggled 1/0 each cycle -> four words hw0..3 with imm FFFF; each word held stable while stalled; OutLast only on hw3.
REQ-045 SHALL cover: Reset pulsed after the second word of a 4-word sequence -> OutValid=0 immediately, InReady=1, no remaining words appear.
REQ-046 SHALL cover the round trip: for random constants, executing the emitted words on the processor model reproduces InConst in Rd; back-to-back requests with InValid held high are each accepted one cycle after the prior OutLast handshake.
